pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core: one instance sits between each pair of stages (F/D, D/E, E/M, M/W) in place of the per-stage hand-written registers. It carries PC, instruction word, a valid bit and `NUM_OPS` 32-bit operand slots, and supports hold (stall), bubble insertion (flush) and a one-entry replay of the last flushed instruction. An optional performance block counts stall and bubble cycles per stage.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_field_reg.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: word width, NOP encoding,
// default reset PC and the per-edge action encoding chosen by the priority decoder.
package pipe_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_REPLAY = 2'd3
    } pipe_act_e;

endpackage

// File: rtl/pipe_field_reg.sv
// One field of a pipeline stage register: the action input selects load, hold,
// bubble value or replay value on each rising edge; asynchronous reset to ResetVal.
module pipe_field_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       Width    = 32,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  pipe_act_e         act,
    input  logic [Width-1:0]  load_val,
    input  logic [Width-1:0]  bubble_val,
    input  logic [Width-1:0]  replay_val,
    output logic [Width-1:0]  q
);

    logic [Width-1:0] q_d;
    logic [Width-1:0] q_q;

    always_comb begin
        q_d = q_q;
        unique case (act)
            ACT_LOAD:   q_d = load_val;
            ACT_HOLD:   q_d = q_q;
            ACT_BUBBLE: q_d = bubble_val;
            ACT_REPLAY: q_d = replay_val;
            default:    q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= ResetVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush (bubble) and one-entry replay.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble cycle counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_OPS         = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter bit          BUBBLE_KEEPS_PC = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      replay_i,
    input  logic                      valid_i,
    input  logic [WORD_W-1:0]         pc_i,
    input  logic [WORD_W-1:0]         instr_i,
    input  logic [WORD_W*NUM_OPS-1:0] ops_i,
    output logic                      valid_o,
    output logic [WORD_W-1:0]         pc_o,
    output logic [WORD_W-1:0]         instr_o,
    output logic [WORD_W*NUM_OPS-1:0] ops_o,
    output logic                      replay_ok_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               bubble_cnt_o
`endif
);

    pipe_act_e act;
    logic      replay_go;
    logic      capture;

    logic                      replay_ok_d, replay_ok_q;
    logic [WORD_W-1:0]         rb_pc_q;
    logic [WORD_W-1:0]         rb_instr_q;
    logic [WORD_W*NUM_OPS-1:0] rb_ops_q;
    logic [WORD_W-1:0]         pc_bubble;

    // A replay request without a captured entry is simply ignored.
    assign replay_go = replay_i & replay_ok_q;
    assign capture   = flush_i & valid_i;
    assign pc_bubble = BUBBLE_KEEPS_PC ? pc_i : '0;

    always_comb begin
        act = ACT_LOAD;
        if (flush_i) begin
            act = ACT_BUBBLE;
        end else if (replay_go) begin
            act = ACT_REPLAY;
        end else if (stall_i) begin
            act = ACT_HOLD;
        end
    end

    always_comb begin
        replay_ok_d = replay_ok_q;
        if (capture) begin
            replay_ok_d = 1'b1;
        end else if (act == ACT_REPLAY) begin
            replay_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replay_ok_q <= 1'b0;
            rb_pc_q     <= '0;
            rb_instr_q  <= INSTR_NOP;
            rb_ops_q    <= '0;
        end else begin
            replay_ok_q <= replay_ok_d;
            if (capture) begin
                rb_pc_q    <= pc_i;
                rb_instr_q <= instr_i;
                rb_ops_q   <= ops_i;
            end
        end
    end

    assign replay_ok_o = replay_ok_q;

    pipe_field_reg #(
        .Width    (1),
        .ResetVal (1'b0)
    ) u_valid (
        .clk        (clk),
        .reset      (reset),
        .act        (act),
        .load_val   (valid_i),
        .bubble_val (1'b0),
        .replay_val (1'b1),
        .q          (valid_o)
    );

    pipe_field_reg #(
        .Width    (WORD_W),
        .ResetVal (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .act        (act),
        .load_val   (pc_i),
        .bubble_val (pc_bubble),
        .replay_val (rb_pc_q),
        .q          (pc_o)
    );

    pipe_field_reg #(
        .Width    (WORD_W),
        .ResetVal (INSTR_NOP)
    ) u_instr (
        .clk        (clk),
        .reset      (reset),
        .act        (act),
        .load_val   (instr_i),
        .bubble_val (INSTR_NOP),
        .replay_val (rb_instr_q),
        .q          (instr_o)
    );

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops
        pipe_field_reg #(
            .Width    (WORD_W),
            .ResetVal ('0)
        ) u_op (
            .clk        (clk),
            .reset      (reset),
            .act        (act),
            .load_val   (ops_i[WORD_W*k +: WORD_W]),
            .bubble_val ({WORD_W{1'b0}}),
            .replay_val (rb_ops_q[WORD_W*k +: WORD_W]),
            .q          (ops_o[WORD_W*k +: WORD_W])
        );
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (act == ACT_HOLD && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (act == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: load, stall, flush, replay, priority and async reset.
// Perf counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        replay_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic [63:0] ops_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [63:0] ops_o;
    logic        replay_ok_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int n_checks;
    int n_fail;

    pipe_stage_reg #(
        .NUM_OPS         (2),
        .RESET_PC        (32'h0000_3000),
        .BUBBLE_KEEPS_PC (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .replay_i     (replay_i),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .ops_i        (ops_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .ops_o        (ops_o),
        .replay_ok_o  (replay_ok_o)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic st, input logic fl, input logic rp, input logic v,
                        input logic [31:0] pc, input logic [31:0] ins, input logic [63:0] ops);
        @(negedge clk);
        stall_i  = st;
        flush_i  = fl;
        replay_i = rp;
        valid_i  = v;
        pc_i     = pc;
        instr_i  = ins;
        ops_i    = ops;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [63:0] ops, input logic rok);
        check({tag, ".valid"}, 64'(valid_o), 64'(v));
        check({tag, ".pc"}, 64'(pc_o), 64'(pc));
        check({tag, ".instr"}, 64'(instr_o), 64'(ins));
        check({tag, ".ops"}, ops_o, ops);
        check({tag, ".replay_ok"}, 64'(replay_ok_o), 64'(rok));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        replay_i = 1'b0;
        valid_i  = 1'b0;
        pc_i     = '0;
        instr_i  = '0;
        ops_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 32'h3000, 32'h0, 64'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Plain load: slot0 = 5, slot1 = 7.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 32'h3421_0001, {32'd7, 32'd5});
        check_out("load", 1'b1, 32'h3004, 32'h3421_0001, {32'd7, 32'd5}, 1'b0);

        // Three stall edges while inputs move on.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3008, 32'hDEAD_BEEF, {32'd9, 32'd8});
            check_out("stall", 1'b1, 32'h3004, 32'h3421_0001, {32'd7, 32'd5}, 1'b0);
        end
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt3", 64'(stall_cnt_o), 64'd3);
`endif

        // Flush with a valid instruction captures it for replay.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300C, 32'h0000_0820, {32'd2, 32'd1});
        check_out("flush", 1'b0, 32'h300C, 32'h0, 64'h0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
        check("bubble_cnt1", 64'(bubble_cnt_o), 64'd1);
`endif

        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h3010, 32'h1234_5678, {32'd4, 32'd3});
        check_out("replay", 1'b1, 32'h300C, 32'h0000_0820, {32'd2, 32'd1}, 1'b0);

        // Flush beats stall; invalid incoming slot leaves the buffer empty.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h3014, 32'hAAAA_0000, {32'd6, 32'd5});
        check_out("flush_stall", 1'b0, 32'h3014, 32'h0, 64'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("bubble_cnt2", 64'(bubble_cnt_o), 64'd2);
        check("stall_cnt_fs", 64'(stall_cnt_o), 64'd3);
`endif

        // Replay with nothing captured degrades to the stall action.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h3018, 32'hBBBB_0000, {32'd1, 32'd1});
        check_out("replay_empty", 1'b0, 32'h3014, 32'h0, 64'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt4", 64'(stall_cnt_o), 64'd4);
`endif

        // Second valid flush overwrites the buffer; replay outranks stall.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3024, 32'h1111_1111, {32'd11, 32'd10});
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3028, 32'h2222_2222, {32'd21, 32'd20});
        check_out("flush2", 1'b0, 32'h3028, 32'h0, 64'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h302C, 32'h3333_3333, {32'd31, 32'd30});
        check_out("replay_over", 1'b1, 32'h3028, 32'h2222_2222, {32'd21, 32'd20}, 1'b0);

        // Pending replay plus loaded outputs, then async reset mid-cycle.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3030, 32'h4444_4444, {32'd41, 32'd40});
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3034, 32'h0000_0777, {32'd51, 32'd50});
        check_out("pre_reset", 1'b1, 32'h3034, 32'h0000_0777, {32'd51, 32'd50}, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 32'h3000, 32'h0, 64'h0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt_rst", 64'(stall_cnt_o), 64'd0);
        check("bubble_cnt_rst", 64'(bubble_cnt_o), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Replay request after reset finds nothing, so the edge is a plain load.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h3040, 32'h5555_5555, {32'd61, 32'd60});
        check_out("post_reset", 1'b1, 32'h3040, 32'h5555_5555, {32'd61, 32'd60}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
